residual_psum_accum: RTL and testbench

- Sits directly downstream of the Layer3 window/macro-control stage. Consumes the per-channel partial sums that the CIM macros return, strobed by data_to_partial_valid. Also consumes the 2x2 residual window for each channel.
- Per output pixel, accumulates NUM_PASS macro passes per channel and adds the 2x2 average of the residual window. The result is saturated to 16 bits and presented with a one-cycle valid to the next layer.

---
 rtl/residual_psum_accum.sv | 166 ++++++++++++++++
 tb/tb_residual_psum_accum.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/residual_psum_accum.sv
// Per-pixel accumulator: sums NUM_PASS macro partial sums per channel, adds the
// floor-averaged 2x2 residual window and saturates the result to 16 bits.
module residual_psum_accum #(
  parameter int unsigned FM_DEPTH = 64,
  parameter int unsigned PSUM_W   = 8,
  parameter int unsigned NUM_PASS = 8,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             verticle_sync,
  input  logic                             mode_in,
  input  logic                             data_to_partial_valid,
  input  logic [FM_DEPTH-1:0][PSUM_W-1:0]  psum_in,
  input  logic                             res_valid,
  input  logic [FM_DEPTH-1:0][3:0][15:0]   res_in,
  output logic [FM_DEPTH-1:0][15:0]        data_out,
  output logic                             data_out_valid,
  output logic                             seq_err
);

  localparam int unsigned OUT_W  = 16;
  localparam int unsigned RSUM_W = OUT_W + 2;
  localparam int unsigned SUM_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int unsigned CNT_W  = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam bit          SINGLE_PASS = (NUM_PASS == 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ADD, OUT} state_e;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 pass_cnt_q, pass_cnt_d;
  logic [FM_DEPTH-1:0][ACC_W-1:0]   acc_q, acc_d;
  logic [FM_DEPTH-1:0][OUT_W-1:0]   res_buf_q, res_buf_d;
  logic                             res_fresh_q, res_fresh_d;
  logic [FM_DEPTH-1:0][OUT_W-1:0]   data_out_q, data_out_d;
  logic                             data_out_valid_q, data_out_valid_d;
  logic                             seq_err_q, seq_err_d;

  logic clear_c;
  logic last_pass_c;

  assign clear_c     = verticle_sync | ~mode_in;
  assign last_pass_c = (pass_cnt_q == CNT_W'(NUM_PASS - 1));

  // Floor average of the 2x2 window; the 18-bit sum cannot overflow.
  function automatic logic [OUT_W-1:0] res_avg(input logic [3:0][OUT_W-1:0] win);
    logic signed [RSUM_W-1:0] s;
    s = RSUM_W'($signed(win[0])) + RSUM_W'($signed(win[1]))
      + RSUM_W'($signed(win[2])) + RSUM_W'($signed(win[3]));
    return OUT_W'(s >>> 2);
  endfunction

  // Final add with clamp to the signed 16-bit range.
  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] acc,
                                               input logic [OUT_W-1:0] res,
                                               input logic             use_res);
    logic [SUM_W-1:0] r;
    logic [SUM_W-1:0] s;
    logic [OUT_W-1:0] o;
    r = use_res ? SUM_W'($signed(res)) : '0;
    s = SUM_W'($signed(acc)) + r;
    if ((s[SUM_W-1:OUT_W-1] == '0) || (s[SUM_W-1:OUT_W-1] == '1)) begin
      o = s[OUT_W-1:0];
    end else if (s[SUM_W-1]) begin
      o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return o;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_c) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (data_to_partial_valid) state_d = SINGLE_PASS ? ADD : ACCUM;
        ACCUM:   if (data_to_partial_valid && last_pass_c) state_d = ADD;
        ADD:     state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pass_cnt_d       = pass_cnt_q;
    acc_d            = acc_q;
    res_buf_d        = res_buf_q;
    res_fresh_d      = res_fresh_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    seq_err_d        = seq_err_q;
    if (clear_c) begin
      pass_cnt_d  = '0;
      acc_d       = '0;
      res_buf_d   = '0;
      res_fresh_d = 1'b0;
      data_out_d  = '0;
      seq_err_d   = 1'b0;
    end else begin
      if (res_valid) begin
        for (int i = 0; i < FM_DEPTH; i++) res_buf_d[i] = res_avg(res_in[i]);
        res_fresh_d = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (data_to_partial_valid) begin
            for (int i = 0; i < FM_DEPTH; i++) acc_d[i] = ACC_W'($signed(psum_in[i]));
            pass_cnt_d = SINGLE_PASS ? '0 : CNT_W'(1);
          end
        end
        ACCUM: begin
          if (data_to_partial_valid) begin
            for (int i = 0; i < FM_DEPTH; i++) acc_d[i] = acc_q[i] + ACC_W'($signed(psum_in[i]));
            pass_cnt_d = last_pass_c ? '0 : pass_cnt_q + CNT_W'(1);
          end
        end
        ADD: begin
          for (int i = 0; i < FM_DEPTH; i++) data_out_d[i] = sat_out(acc_q[i], res_buf_q[i], res_fresh_q);
          data_out_valid_d = 1'b1;
          if (!res_fresh_q || data_to_partial_valid) seq_err_d = 1'b1;
          if (!res_valid) res_fresh_d = 1'b0;
        end
        OUT: begin
          if (data_to_partial_valid) seq_err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q       <= '0;
      acc_q            <= '0;
      res_buf_q        <= '0;
      res_fresh_q      <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      seq_err_q        <= 1'b0;
    end else begin
      pass_cnt_q       <= pass_cnt_d;
      acc_q            <= acc_d;
      res_buf_q        <= res_buf_d;
      res_fresh_q      <= res_fresh_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      seq_err_q        <= seq_err_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_residual_psum_accum.sv
// Bench for residual_psum_accum: pixel-level reference model compared every
// cycle, directed pixels with literal expectations, then random traffic.
module tb_residual_psum_accum;

  localparam int FM = 64;
  localparam int NP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      verticle_sync;
  logic                      mode_in;
  logic                      strobe;
  logic                      res_valid;
  logic [FM-1:0][7:0]        psum_in;
  logic [FM-1:0][3:0][15:0]  res_in;
  logic [FM-1:0][15:0]       data_out;
  logic                      data_out_valid;
  logic                      seq_err;

  int ps_v[FM];
  int rs_v[FM][4];

  always_comb begin
    for (int i = 0; i < FM; i++) begin
      psum_in[i] = 8'(ps_v[i]);
      for (int k = 0; k < 4; k++) res_in[i][k] = 16'(rs_v[i][k]);
    end
  end

  residual_psum_accum #(.FM_DEPTH(FM), .PSUM_W(8), .NUM_PASS(NP), .ACC_W(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .verticle_sync         (verticle_sync),
    .mode_in               (mode_in),
    .data_to_partial_valid (strobe),
    .psum_in               (psum_in),
    .res_valid             (res_valid),
    .res_in                (res_in),
    .data_out              (data_out),
    .data_out_valid        (data_out_valid),
    .seq_err               (seq_err)
  );

  // Reference model: running pixel sum, latest residual average, pending result.
  int m_sum[FM];
  int m_avg[FM];
  int m_pend[FM];
  int exp_data[FM];
  int m_cnt;
  int m_busy;
  bit m_fresh;
  bit m_pend_fresh;
  bit exp_valid;
  bit exp_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FM; i++) begin
      m_sum[i] = 0; m_avg[i] = 0; m_pend[i] = 0; exp_data[i] = 0;
    end
    m_cnt = 0; m_busy = 0; m_fresh = 0; m_pend_fresh = 0;
    exp_valid = 0; exp_err = 0;
  endtask

  // Apply the inputs sampled at the latest rising edge to the model.
  task automatic model_edge();
    exp_valid = 0;
    if (verticle_sync || !mode_in) begin
      model_reset();
      return;
    end
    if (res_valid) begin
      for (int i = 0; i < FM; i++)
        m_avg[i] = (rs_v[i][0] + rs_v[i][1] + rs_v[i][2] + rs_v[i][3]) >>> 2;
      m_fresh = 1;
    end
    if (m_busy == 2) begin
      for (int i = 0; i < FM; i++) exp_data[i] = m_pend[i];
      exp_valid = 1;
      if (!m_pend_fresh) exp_err = 1;
      m_fresh = res_valid;
    end
    if (strobe) begin
      if (m_busy > 0) begin
        exp_err = 1;
      end else begin
        for (int i = 0; i < FM; i++) m_sum[i] += ps_v[i];
        m_cnt++;
        if (m_cnt == NP) begin
          for (int i = 0; i < FM; i++) begin
            m_pend[i] = sat16(m_sum[i] + (m_fresh ? m_avg[i] : 0));
            m_sum[i] = 0;
          end
          m_pend_fresh = m_fresh;
          m_cnt = 0;
          m_busy = 3;
        end
      end
    end
    if (m_busy > 0) m_busy--;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      int bad_lane;
      n_cmp++;
      if (data_out_valid !== exp_valid) begin
        n_bad++;
        $display("FAIL valid @cyc %0d: got %0d want %0d", cyc, data_out_valid, exp_valid);
      end
      n_cmp++;
      if (seq_err !== exp_err) begin
        n_bad++;
        $display("FAIL seq_err @cyc %0d: got %0d want %0d", cyc, seq_err, exp_err);
      end
      bad_lane = -1;
      for (int i = FM - 1; i >= 0; i--)
        if (int'($signed(data_out[i])) != exp_data[i]) bad_lane = i;
      n_cmp++;
      if (bad_lane >= 0) begin
        n_bad++;
        $display("FAIL data_out @cyc %0d lane %0d: got %0d want %0d", cyc, bad_lane,
                 int'($signed(data_out[bad_lane])), exp_data[bad_lane]);
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_pixel(input string name, input int want, input int want_err);
    check_lit({name, " valid"}, int'(data_out_valid), 1);
    check_lit({name, " lane0"}, int'($signed(data_out[0])), want);
    check_lit({name, " lane_last"}, int'($signed(data_out[FM-1])), want);
    check_lit({name, " seq_err"}, int'(seq_err), want_err);
  endtask

  task automatic set_ps(input int v);
    for (int i = 0; i < FM; i++) ps_v[i] = v;
  endtask

  task automatic set_rs(input int r0, input int r1, input int r2, input int r3);
    for (int i = 0; i < FM; i++) begin
      rs_v[i][0] = r0; rs_v[i][1] = r1; rs_v[i][2] = r2; rs_v[i][3] = r3;
    end
  endtask

  // NP strobes of pv; residual (if any) alongside pass NP-1; returns just after the ADD edge.
  task automatic run_pixel(input int pv, input bit give_res,
                           input int r0, input int r1, input int r2, input int r3,
                           input bit stray);
    for (int k = 0; k < NP; k++) begin
      strobe = 1'b1;
      set_ps(pv);
      if (give_res && k == NP - 2) begin
        res_valid = 1'b1;
        set_rs(r0, r1, r2, r3);
      end
      tick();
      strobe = 1'b0;
      res_valid = 1'b0;
    end
    if (stray) begin
      strobe = 1'b1;
      set_ps(100);
    end
    tick();
    strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; verticle_sync = 1'b0; mode_in = 1'b0; strobe = 1'b0; res_valid = 1'b0;
    set_ps(0);
    set_rs(0, 0, 0, 0);
    model_reset();
    #12;
    check_lit("reset valid", int'(data_out_valid), 0);
    check_lit("reset seq_err", int'(seq_err), 0);
    check_lit("reset data", int'($signed(data_out[0])), 0);
    @(negedge clk);
    rst = 1'b0;
    mode_in = 1'b1;
    chk_en = 1'b1;
    tick();

    run_pixel(10, 1'b1, 4, 4, 4, 4, 1'b0);
    check_pixel("basic", 84, 0);
    tick(); tick();
    check_lit("valid one cycle", int'(data_out_valid), 0);
    check_lit("data holds", int'($signed(data_out[3])), 84);

    run_pixel(-3, 1'b1, -1, -1, -1, -2, 1'b0);
    check_pixel("neg floor", -26, 0);
    tick(); tick();

    run_pixel(10, 1'b1, 32767, 32767, 32767, 32767, 1'b0);
    check_pixel("sat pos", 32767, 0);
    tick(); tick();

    run_pixel(-10, 1'b1, -32768, -32768, -32768, -32768, 1'b0);
    check_pixel("sat neg", -32768, 0);
    tick(); tick();

    run_pixel(5, 1'b0, 0, 0, 0, 0, 1'b0);
    check_pixel("no residual", 40, 1);
    tick(); tick(); tick();
    check_lit("seq_err sticky", int'(seq_err), 1);
    verticle_sync = 1'b1;
    tick();
    verticle_sync = 1'b0;
    check_lit("vsync clears err", int'(seq_err), 0);
    check_lit("vsync clears data", int'($signed(data_out[0])), 0);

    for (int k = 0; k < 4; k++) begin
      strobe = 1'b1; set_ps(7); tick();
    end
    strobe = 1'b0;
    mode_in = 1'b0;
    tick();
    mode_in = 1'b1;
    run_pixel(1, 1'b1, 0, 0, 0, 0, 1'b0);
    check_pixel("mid clear", 8, 0);
    tick(); tick();

    run_pixel(2, 1'b1, 8, 8, 8, 8, 1'b1);
    check_pixel("stray in ADD", 24, 1);
    tick(); tick();

    for (int k = 0; k < 3; k++) begin
      strobe = 1'b1; set_ps(9); tick();
    end
    strobe = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_lit("async rst valid", int'(data_out_valid), 0);
    check_lit("async rst err", int'(seq_err), 0);
    check_lit("async rst data", int'($signed(data_out[0])), 0);
    model_reset();
    rst = 1'b0;
    run_pixel(4, 1'b1, 0, 0, 0, 4, 1'b0);
    check_pixel("after rst", 33, 0);
    tick(); tick();

    for (int c = 0; c < 3000; c++) begin
      strobe = ($urandom_range(0, 99) < 55);
      for (int i = 0; i < FM; i++) ps_v[i] = int'($urandom_range(0, 255)) - 128;
      res_valid = ($urandom_range(0, 99) < 15);
      if (res_valid)
        for (int i = 0; i < FM; i++)
          for (int k = 0; k < 4; k++) rs_v[i][k] = int'($signed(16'($urandom)));
      verticle_sync = ($urandom_range(0, 199) == 0);
      mode_in = ($urandom_range(0, 199) != 0);
      tick();
    end
    strobe = 1'b0; res_valid = 1'b0; verticle_sync = 1'b0; mode_in = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
